// File: rtl/ring_osc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_pkg
//  Description : Shared types and constants for the ring-oscillator frequency
//                meter: measurement state encoding, default bank size and
//                channel indices of the oscillator bank (parts a-d x H1/H5/H20).
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_osc_pkg;

    // Default number of oscillator channels in the bank
    localparam int c_default_n_osc = 12;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_t;

    // Channel index of each oscillator: part-major, fan-out minor
    localparam int c_ch_a_h1  = 0;
    localparam int c_ch_a_h5  = 1;
    localparam int c_ch_a_h20 = 2;
    localparam int c_ch_b_h1  = 3;
    localparam int c_ch_b_h5  = 4;
    localparam int c_ch_b_h20 = 5;
    localparam int c_ch_c_h1  = 6;
    localparam int c_ch_c_h5  = 7;
    localparam int c_ch_c_h20 = 8;
    localparam int c_ch_d_h1  = 9;
    localparam int c_ch_d_h5  = 10;
    localparam int c_ch_d_h20 = 11;

endpackage : ring_osc_pkg
`default_nettype wire

// File: rtl/osc_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : osc_edge_sync
//  Description : Two-flop synchroniser for an asynchronous oscillator output
//                followed by a third flop; emits a one-cycle pulse for each
//                rising edge seen at the synchroniser output.
//  Revision    : 1.0 - initial release
// ============================================================================
module osc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise
);

    // sync_q[0]/[1] form the synchroniser, sync_q[2] is the edge-detect history
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw input through the three-stage chain
    always_comb begin
        sync_d = {sync_q[1:0], d_in};
    end

    // Chain flops, cleared by reset so no false edge appears after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule : osc_edge_sync
`default_nettype wire

// File: rtl/ring_osc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_freq_meter
//  Description : Enables one selected ring oscillator, lets it settle, then
//                counts its rising edges over a programmable clk window and
//                reports a saturating count. Single-shot or continuous.
//                Inputs faster than clk/2 alias; this is inherent to sampling.
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_freq_meter
    import ring_osc_pkg::*;
#(
    parameter int N_OSC      = c_default_n_osc,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 10,
    parameter int SETTLE_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_OSC-1:0]         osc_in,
    output logic [N_OSC-1:0]         osc_en,
    input  logic [$clog2(N_OSC)-1:0] sel,
    input  logic [GATE_W-1:0]        gate_cycles,
    input  logic                     cont,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow,
    output logic                     invalid
);

    localparam int             c_sel_w   = $clog2(N_OSC);
    localparam int             c_set_w   = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    meter_state_t         state_q, state_d;
    logic [c_sel_w-1:0]   sel_q, sel_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic                 cont_q, cont_d;
    logic [c_set_w-1:0]   settle_q, settle_d;
    logic [GATE_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
    logic                 ovf_q, ovf_d;
    logic [N_OSC-1:0]     osc_en_q, osc_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 invalid_q, invalid_d;

    logic                 w_sel_valid;
    logic [N_OSC-1:0]     w_sel_onehot;
    logic                 w_osc_sel;
    logic                 w_rise;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_ovf_nxt;

    // Extra MSB keeps the range check correct when N_OSC is a power of two
    assign w_sel_valid = ({1'b0, sel} < (c_sel_w + 1)'(N_OSC));

    // Decode the requested channel and mux the latched channel's oscillator
    always_comb begin
        w_sel_onehot = '0;
        w_osc_sel    = 1'b0;
        for (int i = 0; i < N_OSC; i++) begin
            w_sel_onehot[i] = (sel == c_sel_w'(i));
            if (sel_q == c_sel_w'(i)) begin
                w_osc_sel = osc_in[i];
            end
        end
    end

    osc_edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (w_osc_sel),
        .rise  (w_rise)
    );

    // Saturating edge count including the edge detected this cycle
    always_comb begin
        w_cnt_nxt = edge_cnt_q;
        w_ovf_nxt = ovf_q;
        if (w_rise) begin
            if (edge_cnt_q == c_cnt_max) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = edge_cnt_q + 1'b1;
            end
        end
    end

    // Sequencer next-state: every output is registered, so transitions into
    // DONE load the result and raise done for exactly that one cycle
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gate_d     = gate_q;
        cont_d     = cont_q;
        settle_d   = settle_q;
        win_d      = win_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        osc_en_d   = osc_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        overflow_d = overflow_q;
        invalid_d  = invalid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d      = sel;
                    gate_d     = gate_cycles;
                    cont_d     = cont;
                    settle_d   = '0;
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
                    if (w_sel_valid) begin
                        state_d   = ST_SETTLE;
                        invalid_d = 1'b0;
                        osc_en_d  = w_sel_onehot;
                    end else begin
                        state_d    = ST_DONE;
                        invalid_d  = 1'b1;
                        done_d     = 1'b1;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == c_set_w'(SETTLE_CYC - 1)) begin
                    if (gate_q == '0) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_MEASURE;
                        win_d   = gate_q;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                edge_cnt_d = w_cnt_nxt;
                ovf_d      = w_ovf_nxt;
                if (win_q == GATE_W'(1)) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    count_d    = w_cnt_nxt;
                    overflow_d = w_ovf_nxt;
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (cont_q && !invalid_q && !(start && !cont)) begin
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                    if (gate_q == '0) begin
                        // Zero-length window in continuous mode: report an
                        // empty result every cycle instead of wrapping win_q
                        done_d     = 1'b1;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_MEASURE;
                        win_d   = gate_q;
                    end
                end else begin
                    state_d  = ST_IDLE;
                    osc_en_d = '0;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                osc_en_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Sequencer and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            gate_q     <= '0;
            cont_q     <= 1'b0;
            settle_q   <= '0;
            win_q      <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            osc_en_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gate_q     <= gate_d;
            cont_q     <= cont_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            osc_en_q   <= osc_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            invalid_q  <= invalid_d;
        end
    end

    assign osc_en   = osc_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign invalid  = invalid_q;

endmodule : ring_osc_freq_meter
`default_nettype wire

// File: tb/tb_ring_osc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_osc_freq_meter
//  Description : Self-checking bench for ring_osc_freq_meter. Oscillator
//                waveforms are generated from the clk edge number, so the
//                expected edge count of every window is derived from the
//                waveform model and queued when a measurement is started.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_osc_freq_meter;

    localparam int N_OSC      = 12;
    localparam int CNT_W      = 6;
    localparam int GATE_W     = 10;
    localparam int SETTLE_CYC = 8;
    localparam int SEL_W      = 4;
    localparam int C_MAX      = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_OSC-1:0]   osc_in = '0;
    logic [N_OSC-1:0]   osc_en;
    logic [SEL_W-1:0]   sel;
    logic [GATE_W-1:0]  gate_cycles;
    logic               cont;
    logic               start;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               invalid;

    typedef struct {
        int               edge_no;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             inv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   osc_ch = 0;
    int   osc_per = 0;
    int   osc_ph = 0;

    ring_osc_freq_meter #(
        .N_OSC      (N_OSC),
        .CNT_W      (CNT_W),
        .GATE_W     (GATE_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .osc_in      (osc_in),
        .osc_en      (osc_en),
        .sel         (sel),
        .gate_cycles (gate_cycles),
        .cont        (cont),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (overflow),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    // cyc_n equals the number of the most recent rising edge
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic wave(int k);
        if (osc_per < 2) return 1'b0;
        return ((k + osc_ph) % osc_per) < (osc_per / 2);
    endfunction

    // Selected channel carries the test waveform, all others a period-4 decoy
    function automatic logic [N_OSC-1:0] osc_pattern(int k);
        logic [N_OSC-1:0] v;
        for (int i = 0; i < N_OSC; i++) begin
            v[i] = (i == osc_ch) ? wave(k) : (((k / 2) % 2) == 1);
        end
        return v;
    endfunction

    // Value applied just before edge k is osc_pattern(k)
    always @(negedge clk) osc_in = osc_pattern(cyc_n + 1);

    function automatic int rise_at(int k);
        return (wave(k) && !wave(k - 1)) ? 1 : 0;
    endfunction

    // An input rise applied before edge k is counted at edge k+2
    function automatic int exp_edges(int m0, int gate);
        int c = 0;
        for (int m = m0; m < m0 + gate; m++) c += rise_at(m - 2);
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic sb_push(input int edge_no, input int edges, input logic inv);
        exp_t e;
        e.edge_no = edge_no;
        e.cnt     = (edges > C_MAX) ? CNT_W'(C_MAX) : CNT_W'(edges);
        e.ovf     = (edges > C_MAX);
        e.inv     = inv;
        sb.push_back(e);
    endtask

    task automatic do_start(input int s_sel, input int s_gate, input logic s_cont, output int s_edge);
        @(negedge clk);
        sel         = SEL_W'(s_sel);
        gate_cycles = GATE_W'(s_gate);
        cont        = s_cont;
        start       = 1'b1;
        s_edge      = cyc_n + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks the current cycle first, then advances; returns on the done cycle
    task automatic wait_done(input int budget);
        int   seen = 0;
        exp_t e;
        for (int i = 0; i < budget && seen == 0; i++) begin
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        chk("done_seen", seen, 1);
        if (seen != 0) begin
            chk("sb_pending", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_cycle", cyc_n, e.edge_no);
                chk("done_count", count, e.cnt);
                chk("done_overflow", overflow, e.ovf);
                chk("done_invalid", invalid, e.inv);
            end
        end
    endtask

    task automatic expect_no_done(input int n);
        int k = 0;
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) k++;
        end
        chk("no_extra_done", k, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        rst_n = 1'b0; sel = '0; gate_cycles = '0; cont = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_osc_en", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_invalid", invalid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-shot, channel 3, period 8, 64-cycle window
        osc_ch = 3; osc_per = 8; osc_ph = 0;
        repeat (4) @(negedge clk);
        do_start(3, 64, 1'b0, s);
        sb_push(s + SETTLE_CYC + 64, exp_edges(s + SETTLE_CYC + 1, 64), 1'b0);
        chk("osc_en_settle", osc_en, 12'h008);
        chk("busy_settle", busy, 1);
        repeat (30) @(negedge clk);
        chk("osc_en_measure", osc_en, 12'h008);
        wait_done(100);
        @(negedge clk);
        chk("osc_en_after", osc_en, 0);
        chk("busy_after", busy, 0);

        // Saturation: channel 0 at period 2 over 200 cycles
        osc_ch = 0; osc_per = 2; osc_ph = 0;
        repeat (4) @(negedge clk);
        do_start(0, 200, 1'b0, s);
        sb_push(s + SETTLE_CYC + 200, exp_edges(s + SETTLE_CYC + 1, 200), 1'b0);
        wait_done(260);

        // Out-of-range channel, continuous requested but must not loop
        do_start(13, 64, 1'b1, s);
        sb_push(s, 0, 1'b1);
        chk("osc_en_invalid", osc_en, 0);
        wait_done(5);
        @(negedge clk);
        chk("osc_en_invalid_after", osc_en, 0);
        chk("busy_invalid_after", busy, 0);
        chk("invalid_held", invalid, 1);

        // Continuous, channel 5, period 16, 128-cycle windows
        osc_ch = 5; osc_per = 16; osc_ph = 3;
        repeat (4) @(negedge clk);
        do_start(5, 128, 1'b1, s);
        for (int j = 0; j < 3; j++) begin
            sb_push(s + SETTLE_CYC + 128 + 129 * j,
                    exp_edges(s + SETTLE_CYC + 1 + 129 * j, 128), 1'b0);
        end
        wait_done(160);
        chk("busy_cont", busy, 1);
        @(negedge clk);
        wait_done(140);
        chk("osc_en_cont", osc_en, 12'h020);
        @(negedge clk);
        wait_done(140);
        cont  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_cont_stop", busy, 0);
        chk("osc_en_cont_stop", osc_en, 0);
        expect_no_done(300);

        // Reset for one cycle in the middle of a measurement
        do_start(5, 128, 1'b0, s);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_osc_en", osc_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_done", done, 0);
        expect_no_done(150);
        osc_ch = 3; osc_per = 8; osc_ph = 5;
        repeat (4) @(negedge clk);
        do_start(3, 64, 1'b0, s);
        sb_push(s + SETTLE_CYC + 64, exp_edges(s + SETTLE_CYC + 1, 64), 1'b0);
        wait_done(100);

        // Zero-length window with start pulses while busy
        do_start(3, 0, 1'b0, s);
        sb_push(s + SETTLE_CYC, 0, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        expect_no_done(40);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ring_osc_freq_meter
`default_nettype wire
